// File: rtl/expr_sig_compactor_pkg.sv
// expr_sig_compactor_pkg: shared FSM state type, default MISR polynomial and the 96->32 fold
package expr_sig_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} expr_sig_state_t;
  localparam logic [31:0] EXPR_SIG_POLY = 32'h04C11DB7;
  function automatic logic [31:0] expr_sig_fold(input logic [95:0] d);
    return d[31:0] ^ d[63:32] ^ d[95:64];
  endfunction
endpackage

// File: rtl/expr_sig_compactor_if.sv
// expr_sig_compactor_if: run control, vector handshake and result bus of the compactor
// master = producer/checker side, slave = compactor side.
// golden/mismatch exist only when EXPR_SIG_GOLDEN_CHECK_EN is defined.
interface expr_sig_compactor_if #(parameter int DATA_W = 90) ();
  logic              start;
  logic [15:0]       num_vec;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              busy;
  logic              done;
  logic [31:0]       signature;
  logic [15:0]       vec_count;
`ifdef EXPR_SIG_GOLDEN_CHECK_EN
  logic [31:0]       golden;
  logic              mismatch;
  modport master (output start, num_vec, in_valid, in_data, golden,
                  input in_ready, busy, done, signature, vec_count, mismatch);
  modport slave  (input start, num_vec, in_valid, in_data, golden,
                  output in_ready, busy, done, signature, vec_count, mismatch);
`else
  modport master (output start, num_vec, in_valid, in_data,
                  input in_ready, busy, done, signature, vec_count);
  modport slave  (input start, num_vec, in_valid, in_data,
                  output in_ready, busy, done, signature, vec_count);
`endif
endinterface

// File: rtl/expr_sig_compactor_misr.sv
// expr_sig_misr: SIG_W-bit MISR register with synchronous SEED load and step enable
// Ports: clk, rst_n (async, active-low), load, en, fold_i (folded vector),
// sig_o (current signature), sig_d_o (next value, only with EXPR_SIG_GOLDEN_CHECK_EN).
module expr_sig_misr import expr_sig_pkg::*; #(
  parameter int               SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = EXPR_SIG_POLY,
  parameter logic [SIG_W-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [SIG_W-1:0] fold_i,
`ifdef EXPR_SIG_GOLDEN_CHECK_EN
  output logic [SIG_W-1:0] sig_d_o,
`endif
  output logic [SIG_W-1:0] sig_o
);
  logic [SIG_W-1:0] sig_q, sig_d;
  always_comb sig_d = load ? SEED :
                      en   ? ({sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold_i) :
                             sig_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sig_q <= SEED;
    else        sig_q <= sig_d;
  assign sig_o = sig_q;
`ifdef EXPR_SIG_GOLDEN_CHECK_EN
  assign sig_d_o = sig_d;
`endif
endmodule

// File: rtl/expr_sig_compactor.sv
// expr_sig_compactor: folds each accepted result vector to 32 bits and compresses the run into a MISR signature
// Ports: clk, rst_n (async, active-low), bus (expr_sig_compactor_if.slave:
// start/num_vec run control, in_valid/in_ready/in_data vector handshake,
// busy/done/signature/vec_count results). Optional EXPR_SIG_GOLDEN_CHECK_EN adds golden/mismatch.
module expr_sig_compactor import expr_sig_pkg::*; #(
  parameter int          DATA_W = 90,
  parameter int          SIG_W  = 32,
  parameter logic [31:0] POLY   = EXPR_SIG_POLY,
  parameter logic [31:0] SEED   = 32'h0
) (
  input logic                 clk,
  input logic                 rst_n,
  expr_sig_compactor_if.slave bus
);
  expr_sig_state_t state_q;
  logic [15:0] cnt_q, num_q;
  logic [DATA_W-1:0] data;
  logic [31:0] sig;
  logic accept, xfer, last;
  assign data   = bus.in_data;
  // start is honoured from IDLE and DONE only; a run in progress ignores it
  assign accept = bus.start && state_q != RUN;
  assign xfer   = state_q == RUN && bus.in_valid;
  assign last   = xfer && (cnt_q + 16'd1 == num_q);
`ifdef EXPR_SIG_GOLDEN_CHECK_EN
  logic [31:0] sig_d;
  logic mismatch_q;
`endif
  expr_sig_misr #(.SIG_W(SIG_W), .POLY(POLY), .SEED(SEED)) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .en     (xfer),
    .fold_i (expr_sig_fold(96'(data))),
`ifdef EXPR_SIG_GOLDEN_CHECK_EN
    .sig_d_o(sig_d),
`endif
    .sig_o  (sig)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
`ifdef EXPR_SIG_GOLDEN_CHECK_EN
      mismatch_q <= 1'b0;
`endif
    end else if (accept) begin
      state_q <= bus.num_vec == '0 ? DONE : RUN;
      cnt_q   <= '0;
      num_q   <= bus.num_vec;
`ifdef EXPR_SIG_GOLDEN_CHECK_EN
      // an empty run enters DONE immediately with SEED as its final signature
      mismatch_q <= bus.num_vec == '0 && SEED != bus.golden;
`endif
    end else if (xfer) begin
      cnt_q <= cnt_q + 16'd1;
      if (last) begin
        state_q <= DONE;
`ifdef EXPR_SIG_GOLDEN_CHECK_EN
        mismatch_q <= sig_d != bus.golden;
`endif
      end
    end
  assign bus.in_ready  = state_q == RUN;
  assign bus.busy      = state_q == RUN;
  assign bus.done      = state_q == DONE;
  assign bus.signature = sig;
  assign bus.vec_count = cnt_q;
`ifdef EXPR_SIG_GOLDEN_CHECK_EN
  assign bus.mismatch  = mismatch_q;
`endif
endmodule

// File: doc/expr_sig_compactor.md
# expr_sig_compactor

Downstream consumer for the 90-bit `y` result bus of the expression-under-test blocks in the regression harness. It accepts a programmed number of result vectors over a valid/ready handshake and folds each 90-bit vector to 32 bits. It compresses the folded vectors into a 32-bit MISR signature and presents the signature with the vector count, so one comparison checks a whole regression run.

## Interface
- `DATA_W`, default 90: width of the result vector. Supported range is 1..96.
- `SIG_W`, default 32: width of the signature. Fixed at 32; other values are unsupported.
- `POLY`, default 32'h04C11DB7: MISR feedback polynomial.
- `SEED`, default 32'h00000000: signature value loaded on `start`.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `start`  in  1  one-cycle request that begins a run.
- `num_vec`  in  16  number of vectors in the run. Sampled on an accepted `start`.
- `in_valid`  in  1  a result vector is present on `in_data`.
- `in_ready`  out  1  the compactor will accept `in_data` this cycle.
- `in_data`  in  DATA_W  result vector (the `y` bus).
- `busy`  out  1  a run is in progress.
- `done`  out  1  the run is complete and the signature is stable.
- `signature`  out  32  current MISR value.
- `vec_count`  out  16  number of vectors accepted in the current run.
- `golden`  in  32  expected signature. Present only with `EXPR_SIG_GOLDEN_CHECK_EN`.
- `mismatch`  out  1  the final signature differs from `golden`. Present only with `EXPR_SIG_GOLDEN_CHECK_EN`.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:** `in_ready`=0. When `start`=1:
  - `signature`<=SEED, `vec_count`<=0, latch `num_vec`.
  - If `num_vec`=0, go to DONE. Otherwise go to RUN.
- **RUN:** `in_ready`=1 and `busy`=1. A transfer occurs when `in_valid`&&`in_ready`. On each transfer:
  - `signature`<=step(signature, fold(in_data)).
  - `vec_count`<=`vec_count`+1.
  - On the transfer where `vec_count`+1 equals the latched `num_vec`, go to DONE.
- **DONE:** `done`=1, `in_ready`=0, and `signature`/`vec_count` are held.
  - `start` restarts the run exactly as it does from IDLE.
  - The block never returns to IDLE except through reset.
- **`start` during RUN** is ignored. The run continues unaffected.
- **Fold:** zero-pad `in_data` to 96 bits, then XOR its three 32-bit slices: bits [31:0]^[63:32]^[95:64].
- **Step:** next = ({sig[30:0],1'b0} ^ (sig[31] ? POLY : 0)) ^ fold. Addition in the step is mod 2 only; there is no carry.
- **`vec_count`** does not wrap, because `num_vec` bounds it at 65535.
- **Reset values:** state=IDLE, `signature`=SEED, `vec_count`=0, `busy`=0, `done`=0, `in_ready`=0, `mismatch`=0.
- **Reset mid-run:** the partial run is discarded and all outputs return to their reset values.

## Timing
- `in_ready`, `busy` and `done` are decoded from registered state only. None of them has a combinational path from any input.
- `start` accepted at edge N:
  - RUN and `in_ready`=1 are visible after edge N.
  - If `num_vec`=0, `done`=1 is visible after edge N.
- A transfer at edge N updates `signature` and `vec_count` after edge N.
- Throughput is one vector per cycle.
- The last transfer at edge N makes `done`=1 visible after edge N, in the same cycle as the final signature.
- `in_data` is held by the producer until the transfer. The compactor never stalls mid-run except through `in_valid`=0.

## Configuration
- `EXPR_SIG_GOLDEN_CHECK_EN` defined:
  - The `golden` and `mismatch` ports exist.
  - On entry to DONE, `mismatch` is registered as (final signature != `golden`).
  - `mismatch` is held through DONE and cleared on `start`.
- `EXPR_SIG_GOLDEN_CHECK_EN` undefined:
  - The ports and the compare logic are absent.
  - All other behaviour is identical.

## Structure
- Package `expr_sig_pkg` contains:
  - The state enum `expr_sig_state_t` {IDLE, RUN, DONE}.
  - The `EXPR_SIG_POLY` constant.
  - The `expr_sig_fold` function.
- Sub-module `expr_sig_misr`:
  - A 32-bit register with synchronous `load`/`en` inputs and SEED load.
  - Applies the step function.
  - Instantiated once in the top level.

## Test plan
- SEED=0, `num_vec`=1, `in_data`=90'h1 -> `done`=1 and `signature`=32'h00000001 one edge after the transfer, `vec_count`=1.
- SEED=0, `num_vec`=2, vectors 90'h1 then 90'h0 -> `signature`=32'h00000002, `vec_count`=2.
- SEED=32'h80000000, `num_vec`=1, `in_data`=0 -> `signature`=32'h04C11DB7. This checks the feedback path.
- `in_data` with bits 64 and 0 set, SEED=0 -> `signature`=0. This checks the fold across slices.
- `num_vec`=0 -> `done`=1 on the edge after `start`, `signature`=SEED, `in_ready` never asserted.
- `num_vec`=3 with `in_valid` toggling, and `rst_n` asserted after 2 transfers -> all outputs at reset values. A following `start` runs to completion with the correct signature.
